// File: rtl/pcieifc_fifo_rd_stream_if.sv
// Bundle of the upstream FIFO read port, flush control and the downstream stream.
// The master side is the read-stream block; the slave side is its environment.
interface pcieifc_fifo_rd_stream_if #(
  parameter int DATA_WIDTH = 192,
  parameter int BUF_DEPTH  = 4
);
  localparam int CNT_W = $clog2(BUF_DEPTH) + 1;

  logic                  fifo_empty;
  logic                  fifo_ren;
  logic [DATA_WIDTH-1:0] fifo_dout;
  logic                  flush;
  logic                  m_valid;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_ready;
  logic [CNT_W-1:0]      buf_cnt;

  modport master (
    input  fifo_empty, fifo_dout, flush, m_ready,
    output fifo_ren, m_valid, m_data, buf_cnt
  );

  modport slave (
    output fifo_empty, fifo_dout, flush, m_ready,
    input  fifo_ren, m_valid, m_data, buf_cnt
  );
endinterface

// File: rtl/pcieifc_fifo_rd_stream.sv
// Turns a fixed-latency FIFO read port into a valid/ready stream through a small
// prefetch buffer; reads are issued only when buffer space is guaranteed.

module pcieifc_fifo_rd_stream_chk #(
  parameter int BUF_DEPTH = 4,
  parameter int CNT_W     = 3
) (
  input logic             clk,
  input logic             rst,
  input logic             push_i,
  input logic             pop_i,
  input logic [CNT_W-1:0] cnt_i
);
  // A return landing in a full buffer with no pop means the credit rule was broken.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push_i && !pop_i && (cnt_i == CNT_W'(BUF_DEPTH))));
endmodule

module pcieifc_fifo_rd_stream #(
  parameter int DATA_WIDTH = 192,
  parameter int RD_LAT     = 1,
  parameter int BUF_DEPTH  = 4
) (
  input logic                     clk,
  input logic                     rst,
  pcieifc_fifo_rd_stream_if.master io
);
  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SUM_W = CNT_W + 1;

  logic [RD_LAT-1:0]     infl_q, infl_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] mem_q [BUF_DEPTH];
  logic [CNT_W-1:0]      inflight_s;
  logic [SUM_W-1:0]      credit_s;
  logic                  push_s, pop_s, ren_s, clr_s, valid_s;

  assign valid_s = (cnt_q != '0);
  assign pop_s   = valid_s && io.m_ready;
  assign push_s  = infl_q[RD_LAT-1];
  assign clr_s   = rst || io.flush;

  always_comb begin
    inflight_s = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      inflight_s = inflight_s + CNT_W'(infl_q[i]);
    end
  end

  // Space still unclaimed after this cycle's pop decides whether another read may go out.
  always_comb begin
    credit_s = SUM_W'(cnt_q) + SUM_W'(inflight_s) - SUM_W'(pop_s);
    ren_s    = !io.fifo_empty && !clr_s && (credit_s < SUM_W'(BUF_DEPTH));
  end

  always_comb begin
    infl_d   = RD_LAT'({infl_q, ren_s});
    wr_ptr_d = wr_ptr_q + PTR_W'(push_s);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop_s);
    cnt_d    = cnt_q + CNT_W'(push_s) - CNT_W'(pop_s);
    if (clr_s) begin
      infl_d   = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      infl_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      infl_q   <= infl_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Returns that land during a flush belong to reads being discarded.
  always_ff @(posedge clk) begin
    if (push_s && !clr_s) begin
      mem_q[wr_ptr_q] <= io.fifo_dout;
    end
  end

  assign io.fifo_ren = ren_s;
  assign io.m_valid  = valid_s;
  assign io.m_data   = valid_s ? mem_q[rd_ptr_q] : '0;
  assign io.buf_cnt  = cnt_q;

  pcieifc_fifo_rd_stream_chk #(
    .BUF_DEPTH (BUF_DEPTH),
    .CNT_W     (CNT_W)
  ) u_chk (
    .clk    (clk),
    .rst    (rst),
    .push_i (push_s),
    .pop_i  (pop_s),
    .cnt_i  (cnt_q)
  );
endmodule
